instr_fetch: RTL and testbench

- Front-end fetch unit: produces the 32-bit encoded instruction stream consumed by the decode/control path.
- Keeps the fetch PC and issues in-order word requests to instruction memory.
- Buffers returned words with their PCs and hands them downstream over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered instructions and discarding stale responses.

---
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bus bundle for the instruction fetch unit. Groups the
//                instruction-memory request/response channel, the redirect
//                input from the control path and the decoded-instruction
//                valid/ready output channel.
//  Modports    : master - fetch unit view (drives requests and instructions)
//                slave  - environment view (memory, control path, decoder)
//  Signals     : imem_req_valid/ready/addr  request channel
//                imem_rsp_valid/data        in-order response channel
//                redirect_valid/pc          PC change request
//                instr_valid/ready/data/pc  instruction output channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Front-end fetch unit. Holds the fetch PC, issues in-order
//                word requests to instruction memory under a credit limit,
//                buffers returned words with their PCs and presents them to
//                the decoder over valid/ready. A redirect flushes everything
//                buffered and marks in-flight responses as stale.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - instr_fetch_if.master (memory, redirect, decoder)
//  Parameters  : RESET_PC - first fetch address after reset
//                DEPTH    - buffer entries / max requests in flight (2..8,
//                           power of two)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam int unsigned c_sum_w = c_cnt_w + 2;
  localparam logic [c_sum_w-1:0] c_depth   = c_sum_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // Architectural state
  logic [31:0]        r_fetch_pc;
  logic [c_cnt_w-1:0] r_live;    // requests whose responses will be kept
  logic [c_cnt_w-1:0] r_stale;   // requests whose responses will be dropped
  logic [c_cnt_w-1:0] r_count;   // buffered instructions

  // Instruction buffer and PC queue (circular, DEPTH is a power of two so
  // pointers wrap naturally)
  logic [31:0]        r_buf_data [DEPTH];
  logic [31:0]        r_buf_pc   [DEPTH];
  logic [31:0]        r_pcq      [DEPTH];
  logic [c_ptr_w-1:0] r_buf_rd, r_buf_wr;
  logic [c_ptr_w-1:0] r_pcq_rd, r_pcq_wr;

  logic [c_sum_w-1:0] w_used;
  logic [c_cnt_w-1:0] w_inflight;
  logic [c_cnt_w-1:0] w_rsp_one;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_rsp_take;
  logic               w_rsp_drop;
  logic               w_push;
  logic               w_pop;
  logic               w_have;

  // Every issued request reserves a buffer slot until its instruction is
  // consumed (or its response is discarded), so the buffer can never overflow.
  assign w_used      = {2'b00, r_live} + {2'b00, r_stale} + {2'b00, r_count};
  assign w_inflight  = r_live + r_stale;
  assign w_req_valid = !reset && !bus.redirect_valid && (w_used < c_depth);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is spurious and ignored.
  assign w_rsp_take  = bus.imem_rsp_valid && (w_inflight != '0);
  assign w_rsp_drop  = w_rsp_take && (r_stale != '0);
  assign w_rsp_one   = {{(c_cnt_w-1){1'b0}}, w_rsp_take};
  assign w_push      = w_rsp_take && (r_stale == '0) && !bus.redirect_valid;
  assign w_have      = (r_count != '0);
  assign w_pop       = w_have && bus.instr_ready && !bus.redirect_valid;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = w_have;
  assign bus.instr_data     = w_have ? r_buf_data[r_buf_rd] : 32'h0;
  assign bus.instr_pc       = w_have ? r_buf_pc[r_buf_rd]   : 32'h0;

  // Control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_live     <= '0;
      r_stale    <= '0;
      r_count    <= '0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight becomes stale, minus a response that
      // lands (and is dropped) in this very cycle.
      r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      r_stale    <= r_stale + r_live - w_rsp_one;
      r_live     <= '0;
      r_count    <= '0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pcq_wr   <= r_pcq_wr + c_ptr_one;
      end
      if (w_push) begin
        r_pcq_rd <= r_pcq_rd + c_ptr_one;
        r_buf_wr <= r_buf_wr + c_ptr_one;
      end
      if (w_pop) begin
        r_buf_rd <= r_buf_rd + c_ptr_one;
      end
      if (w_rsp_drop) begin
        r_stale <= r_stale - c_cnt_one;
      end
      case ({w_req_fire, w_push})
        2'b10:   r_live <= r_live + c_cnt_one;
        2'b01:   r_live <= r_live - c_cnt_one;
        default: r_live <= r_live;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through the counters.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_buf_data[r_buf_wr] <= bus.imem_rsp_data;
      r_buf_pc[r_buf_wr]   <= r_pcq[r_pcq_rd];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch (RESET_PC = 0x100,
//                DEPTH = 2). A per-cycle vector table drives the memory,
//                redirect and decoder inputs and holds hand-derived expected
//                outputs; a few hand-written sequences cover async reset and
//                a bounded wait for the first instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          rr;     // imem_req_ready
    bit          rv;     // imem_rsp_valid
    logic [31:0] rd;     // imem_rsp_data
    bit          redv;
    logic [31:0] redpc;
    bit          ir;     // instr_ready
    bit          erv;    // expected imem_req_valid
    logic [31:0] era;    // expected imem_req_addr
    bit          eiv;    // expected instr_valid
    logic [31:0] eipc;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  // Memory content model: each word is derived from its address.
  function automatic logic [31:0] dw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ra: address whose word is returned when rv=1; eipc: expected head PC.
  task automatic add(input bit rst, input bit rr, input bit rv, input logic [31:0] ra,
                     input bit redv, input logic [31:0] redpc, input bit ir,
                     input bit erv, input logic [31:0] era, input bit eiv,
                     input logic [31:0] eipc);
    vec_t v;
    v.rst = rst; v.rr = rr; v.rv = rv; v.rd = rv ? dw(ra) : 32'h0;
    v.redv = redv; v.redpc = redpc; v.ir = ir;
    v.erv = erv; v.era = era; v.eiv = eiv;
    v.eipc = eiv ? eipc : 32'h0;
    v.edat = eiv ? dw(eipc) : 32'h0;
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, RST_PC, 0, 0);
  endtask

  initial begin
    bit found;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    //      rst rr rv ra            redv redpc         ir | erv era           eiv eipc
    add_rst();
    // Streaming with 1-cycle memory, decoder always ready
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h100,       0, 0);
    add(0, 1, 1, 32'h100,      0, 0,            1,   1, 32'h104,       0, 0);
    add(0, 1, 1, 32'h104,      0, 0,            1,   0, 32'h108,       1, 32'h100);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h108,       1, 32'h104);
    add(0, 1, 1, 32'h108,      0, 0,            1,   1, 32'h10C,       0, 0);
    add(0, 1, 1, 32'h10C,      0, 0,            1,   0, 32'h110,       1, 32'h108);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h110,       1, 32'h10C);
    add(0, 0, 1, 32'h110,      0, 0,            1,   1, 32'h114,       0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h114,       1, 32'h110);
    // Decoder stall with full buffer, then release
    add_rst();
    add(0, 1, 0, 0,            0, 0,            0,   1, 32'h100,       0, 0);
    add(0, 1, 1, 32'h100,      0, 0,            0,   1, 32'h104,       0, 0);
    add(0, 1, 1, 32'h104,      0, 0,            0,   0, 32'h108,       1, 32'h100);
    add(0, 1, 0, 0,            0, 0,            0,   0, 32'h108,       1, 32'h100);
    add(0, 1, 0, 0,            0, 0,            1,   0, 32'h108,       1, 32'h100);
    add(0, 1, 0, 0,            0, 0,            0,   1, 32'h108,       1, 32'h104);
    add(0, 1, 1, 32'h108,      0, 0,            0,   0, 32'h10C,       1, 32'h104);
    // Redirect with one buffered entry and a response in the same cycle
    add(0, 0, 0, 0,            0, 0,            1,   0, 32'h10C,       1, 32'h104);
    add(0, 1, 0, 0,            0, 0,            0,   1, 32'h10C,       1, 32'h108);
    add(0, 1, 1, 32'h10C,      1, 32'h300,      1,   0, 32'h110,       1, 32'h108);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h300,       0, 0);
    add(0, 0, 1, 32'h300,      0, 0,            1,   1, 32'h304,       0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h304,       1, 32'h300);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h304,       0, 0);
    // Two requests in flight, redirect to an unaligned PC
    add_rst();
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h100,       0, 0);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h104,       0, 0);
    add(0, 1, 0, 0,            1, 32'h2003,     1,   0, 32'h108,       0, 0);
    add(0, 1, 1, 32'h100,      0, 0,            1,   0, 32'h2000,      0, 0);
    add(0, 1, 1, 32'h104,      0, 0,            1,   1, 32'h2000,      0, 0);
    add(0, 0, 1, 32'h2000,     0, 0,            1,   1, 32'h2004,      0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h2004,      1, 32'h2000);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h2004,      0, 0);
    // Request-ready toggling 1,0,0,1
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h2004,      0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h2008,      0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h2008,      0, 0);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'h2008,      0, 0);
    add(0, 0, 1, 32'h2004,     0, 0,            1,   0, 32'h200C,      0, 0);
    add(0, 0, 1, 32'h2008,     0, 0,            1,   0, 32'h200C,      1, 32'h2004);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h200C,      1, 32'h2008);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h200C,      0, 0);
    // Redirect to the top word: PC wraps to 0
    add(0, 1, 0, 0,            1, 32'hFFFF_FFFC, 1,  0, 32'h200C,      0, 0);
    add(0, 1, 0, 0,            0, 0,            1,   1, 32'hFFFF_FFFC, 0, 0);
    add(0, 1, 1, 32'hFFFF_FFFC, 0, 0,           1,   1, 32'h0,         0, 0);
    add(0, 0, 1, 32'h0,        0, 0,            1,   0, 32'h4,         1, 32'hFFFF_FFFC);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h4,         1, 32'h0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h4,         0, 0);
    // Back-to-back redirects: the last one wins
    add(0, 0, 0, 0,            1, 32'h500,      1,   0, 32'h4,         0, 0);
    add(0, 0, 0, 0,            1, 32'h606,      1,   0, 32'h500,       0, 0);
    add(0, 0, 0, 0,            0, 0,            1,   1, 32'h604,       0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset              = tbl[i].rst;
      bus.imem_req_ready = tbl[i].rr;
      bus.imem_rsp_valid = tbl[i].rv;
      bus.imem_rsp_data  = tbl[i].rd;
      bus.redirect_valid = tbl[i].redv;
      bus.redirect_pc    = tbl[i].redpc;
      bus.instr_ready    = tbl[i].ir;
      #1;
      chk($sformatf("row%0d req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, tbl[i].erv});
      chk($sformatf("row%0d req_addr", i), bus.imem_req_addr, tbl[i].era);
      chk($sformatf("row%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, tbl[i].eiv});
      if (tbl[i].eiv || tbl[i].rst) begin
        chk($sformatf("row%0d instr_pc", i), bus.instr_pc, tbl[i].eipc);
        chk($sformatf("row%0d instr_data", i), bus.instr_data, tbl[i].edat);
      end
    end

    // Hand-written: fresh reset, one fetch, bounded wait for delivery, then
    // an asynchronous reset assertion in the middle of a cycle.
    @(negedge clk);
    reset = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0; bus.instr_ready    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    chk("seq first req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("seq first req_addr", bus.imem_req_addr, RST_PC);
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = dw(RST_PC);
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    #1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.instr_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("seq wait instr_valid", {31'b0, found}, 32'd1);
    chk("seq instr_pc", bus.instr_pc, RST_PC);
    chk("seq instr_data", bus.instr_data, dw(RST_PC));
    #2;
    reset = 1'b1;
    #1;
    chk("seq async reset instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("seq async reset req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("seq async reset req_addr", bus.imem_req_addr, RST_PC);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
